// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the mux pattern sequencer.
// Holds the sequencer state encoding, the error-counter width and the max-code helper.
package mux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } seq_state_e;

    localparam int unsigned ERR_W = 8;

    // Highest code of an n-bit pattern bus.
    function automatic int unsigned MAX_CODE(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/mux_seq_dwell_timer.sv
// Dwell counter for the mux pattern sequencer: load, decrement toward zero, zero flag.
module mux_seq_dwell_timer
    import mux_seq_pkg::*;
#(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               dec,
    output logic               zero_c
);

    logic [DWELL_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - DWELL_W'(1);
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/mux_pattern_sequencer.sv
// Clocked stimulus sequencer that sweeps {sel,in1,in0} through every code with a
// programmable dwell. Optional output checker enabled by defining MUX_SEQ_CHECK_EN.
module mux_pattern_sequencer
    import mux_seq_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 3,
    parameter int unsigned DWELL_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic                  mux_out,
    output logic [NUM_INPUTS-1:0] pattern,
    output logic                  sel,
    output logic                  in1,
    output logic                  in0,
    output logic                  busy,
    output logic                  done,
    output logic [ERR_W-1:0]      err_cnt
);

    localparam logic [NUM_INPUTS-1:0] MAX_PAT = NUM_INPUTS'(MAX_CODE(NUM_INPUTS));

    seq_state_e            state_q, state_nxt;
    logic [NUM_INPUTS-1:0] pattern_q, pattern_nxt;
    logic [DWELL_W-1:0]    dwell_m1_q, dwell_m1_nxt;
    logic                  busy_q, busy_nxt;
    logic                  done_q, done_nxt;
    logic                  tmr_load_c, tmr_dec_c, tmr_zero_c;
    logic [DWELL_W-1:0]    tmr_load_val_c;

    mux_seq_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_c),
        .load_val (tmr_load_val_c),
        .dec      (tmr_dec_c),
        .zero_c   (tmr_zero_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pattern_q  <= '0;
            dwell_m1_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            pattern_q  <= pattern_nxt;
            dwell_m1_q <= dwell_m1_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
        end
    end

    // Sweep control; the timer holds D-1 so a zero dwell collapses to one cycle per code.
    always_comb begin
        state_nxt      = state_q;
        pattern_nxt    = pattern_q;
        dwell_m1_nxt   = dwell_m1_q;
        busy_nxt       = busy_q;
        done_nxt       = 1'b0;
        tmr_load_c     = 1'b0;
        tmr_dec_c      = 1'b0;
        tmr_load_val_c = dwell_m1_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dwell_m1_nxt   = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));
                    tmr_load_c     = 1'b1;
                    tmr_load_val_c = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));
                    pattern_nxt    = '0;
                    busy_nxt       = 1'b1;
                    state_nxt      = RUN;
                end
            end
            RUN: begin
                if (tmr_zero_c) begin
                    if (pattern_q != MAX_PAT) begin
                        pattern_nxt = pattern_q + NUM_INPUTS'(1);
                        tmr_load_c  = 1'b1;
                    end else begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = FIN;
                    end
                end else begin
                    tmr_dec_c = 1'b1;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign pattern = pattern_q;
    assign sel     = pattern_q[NUM_INPUTS-1];
    assign in1     = pattern_q[1];
    assign in0     = pattern_q[0];
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef MUX_SEQ_CHECK_EN
    logic [ERR_W-1:0] err_cnt_q, err_cnt_nxt;
    logic             exp_out_c;

    assign exp_out_c = sel ? in1 : in0;

    // Compare only in the final dwell cycle of each code, after the mux has settled.
    always_comb begin
        err_cnt_nxt = err_cnt_q;
        if ((state_q == IDLE) && start) begin
            err_cnt_nxt = '0;
        end else if ((state_q == RUN) && tmr_zero_c && (mux_out != exp_out_c)
                     && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_nxt = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_nxt;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_mux_out;
    assign unused_mux_out = mux_out;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_mux_pattern_sequencer.sv
// Self-checking bench for mux_pattern_sequencer: per-cycle scoreboard of pattern/busy/done/err_cnt.
module tb_mux_pattern_sequencer;

    typedef struct {
        logic [2:0] pat;
        logic       busy;
        logic       done;
        logic [7:0] err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dwell;
    logic       mux_out;
    logic       mux_inv;
    logic [2:0] pattern;
    logic       sel, in1, in0, busy, done;
    logic [7:0] err_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Reference 2:1 mux, optionally inverted to provoke checker mismatches.
    assign mux_out = (sel ? in1 : in0) ^ mux_inv;

    mux_pattern_sequencer #(
        .NUM_INPUTS (3),
        .DWELL_W    (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .dwell   (dwell),
        .mux_out (mux_out),
        .pattern (pattern),
        .sel     (sel),
        .in1     (in1),
        .in0     (in0),
        .busy    (busy),
        .done    (done),
        .err_cnt (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_err(input int c, input bit inv);
`ifdef MUX_SEQ_CHECK_EN
        return inv ? 8'(c) : 8'd0;
`else
        return 8'd0;
`endif
    endfunction

    task automatic check_now(input exp_t e, input string tag);
        chk({tag, ".pattern"}, 32'(pattern), 32'(e.pat));
        chk({tag, ".busy"},    32'(busy),    32'(e.busy));
        chk({tag, ".done"},    32'(done),    32'(e.done));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(e.err));
        chk({tag, ".sel"},     32'(sel),     32'(e.pat[2]));
    endtask

    // Expected per-cycle trace of a full sweep plus one idle cycle afterwards.
    task automatic push_sweep(input int d_eff, input bit inv);
        exp_t e;
        for (int c = 0; c < 8; c++) begin
            for (int j = 0; j < d_eff; j++) begin
                e.pat = 3'(c); e.busy = 1'b1; e.done = 1'b0; e.err = exp_err(c, inv);
                sb.push_back(e);
            end
        end
        e.pat = 3'd7; e.busy = 1'b0; e.done = 1'b1; e.err = exp_err(8, inv);
        sb.push_back(e);
        e.done = 1'b0;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [7:0] dw);
        dwell = dw;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Pops one entry per cycle; poke_idx injects a start/dwell disturbance, stop_idx aborts.
    task automatic drain(input string tag, input int poke_idx, input int stop_idx);
        exp_t e;
        int   i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_now(e, tag);
            if (i == stop_idx) begin
                sb.delete();
                break;
            end
            if (i == poke_idx) begin
                start = 1'b1;
                dwell = 8'd9;
            end else if (i == poke_idx + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            i++;
        end
    endtask

    initial begin
        exp_t idle0;
        rst_n   = 1'b0;
        start   = 1'b0;
        dwell   = 8'd4;
        mux_inv = 1'b0;
        idle0.pat = 3'd0; idle0.busy = 1'b0; idle0.done = 1'b0; idle0.err = 8'd0;

        // Reset held two cycles
        @(negedge clk);
        check_now(idle0, "reset0");
        @(negedge clk);
        check_now(idle0, "reset1");
        rst_n = 1'b1;
        @(negedge clk);
        check_now(idle0, "idle");

        // dwell=4 full sweep
        push_sweep(4, 1'b0);
        do_start(8'd4);
        drain("sweep_d4", -1, -1);
        chk("hold_max", 32'(pattern), 32'd7);

        // dwell=0 behaves as 1
        push_sweep(1, 1'b0);
        do_start(8'd0);
        drain("sweep_d0", -1, -1);

        // start re-pulse and dwell change at code 3 are ignored
        push_sweep(4, 1'b0);
        do_start(8'd4);
        drain("ignore_start", 12, -1);

        // reset at code 5 aborts with no done pulse
        push_sweep(4, 1'b0);
        do_start(8'd4);
        drain("pre_reset", -1, 20);
        rst_n = 1'b0;
        @(negedge clk);
        check_now(idle0, "mid_reset");
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_now(idle0, "post_reset");
        end

        // restart from 0 after reset
        push_sweep(2, 1'b0);
        do_start(8'd2);
        drain("restart_d2", -1, -1);

        // inverted mux: checker counts one mismatch per code when enabled
        mux_inv = 1'b1;
        push_sweep(3, 1'b1);
        do_start(8'd3);
        drain("inv_mux", -1, -1);
        mux_inv = 1'b0;

        // accepted start clears the error count; max dwell of 255
        push_sweep(255, 1'b0);
        do_start(8'd255);
        drain("sweep_d255", -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
